hamming_encoder: RTL



---
 rtl/hamming_encoder.sv | 115 +++++++++++
 1 files changed

// File: rtl/hamming_encoder.sv
// Hamming(7,4) encoder with a small valid/ready output queue, a one-shot
// single-bit error-injection hook and a completed-transfer counter.
// Codeword bit k holds Hamming position k+1. Parity sits at positions 1, 2 and 4.
module hamming_encoder #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [6:0]       out_data,
   input  logic             inj_req,
   input  logic [2:0]       inj_pos,
   output logic             inj_pending,
   output logic [CNT_W-1:0] word_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic       pending;
      logic [2:0] pos;
   } inj_t;

   inj_t                  inj_q;
   logic [DEPTH-1:0][6:0] mem;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [OW-1:0]         occ;
   logic                  run;       // holds in_ready low until the first edge after reset
   logic                  push, pop;
   logic [6:0]            enc, flip, wr_word;

   function automatic logic [6:0] encode(input logic [3:0] d);
      logic [6:0] c;
      c[2] = d[0];
      c[4] = d[1];
      c[5] = d[2];
      c[6] = d[3];
      c[0] = c[2] ^ c[4] ^ c[6];
      c[1] = c[2] ^ c[5] ^ c[6];
      c[3] = c[4] ^ c[5] ^ c[6];
      return c;
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign in_ready    = run && (occ < OW'(DEPTH));
   assign out_valid   = (occ != '0);
   assign out_data    = out_valid ? mem[rd_ptr] : '0;
   assign push        = in_valid && in_ready;
   assign pop         = out_valid && out_ready;
   assign inj_pending = inj_q.pending;

   // Encode the payload and apply the armed flip (state from before this edge).
   always_comb begin
      flip = '0;
      enc  = encode(in_data);
      for (int k = 0; k < 7; k++)
         flip[k] = inj_q.pending && (inj_q.pos == 3'(k + 1));
      wr_word = enc ^ flip;
   end

   // Input enable comes up one edge after reset is released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) run <= 1'b0;
      else       run <= 1'b1;
   end

   // Circular queue; reset discards contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_word;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   occ <= occ + OW'(1);
            2'b01:   occ <= occ - OW'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Injection arm/consume; a new request wins over consumption on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inj_q <= '0;
      end else if (inj_req && (inj_pos != 3'd0)) begin
         inj_q.pending <= 1'b1;
         inj_q.pos     <= inj_pos;
      end else if (push && inj_q.pending) begin
         inj_q <= '0;
      end
   end

   // Completed output transfers, wrapping naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)    word_count <= '0;
      else if (pop) word_count <= word_count + CNT_W'(1);
   end

endmodule
